alu_multicycle: RTL and testbench
=================================

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
- REQ-001: Parameter DATA_W, default `DATA_WIDTH (32), operand and result width.
- REQ-002: Parameter OPRN_W, default `ALU_OPRN_WIDTH (6), opcode width.
- REQ-003: CLK  input  1  single clock; every register updates on its rising edge.
- REQ-004: RST  input  1  asynchronous, active-low reset.
- REQ-005: START  input  1  request strobe, sampled on the CLK rising edge.
- REQ-006: OP1, OP2  input  DATA_W  operands, captured with START.
- REQ-007: OPRN  input  OPRN_W  opcode, captured with START.
- REQ-008: BUSY  output  1  high while an accepted operation is executing.
- REQ-009: DONE  output  1  one-cycle pulse marking OUT/ZERO/ERR valid.
- REQ-010: OUT  output  DATA_W  registered result, held until the next DONE.
- REQ-011: ZERO  output  1  registered; equals (OUT == 0).
- REQ-012: ERR  output  1  registered; high when the completed opcode is unsupported.

Function
- REQ-013: States: IDLE, EXEC, MUL, FIN; BUSY=1 in EXEC and MUL only; DONE=1 in FIN only.
- REQ-014: In IDLE or FIN, START=1 at an edge latches OP1/OP2/OPRN; next state is MUL for opcode 0x03, otherwise EXEC.
- REQ-015: START is ignored in EXEC and MUL; the latched operands and opcode stay unchanged.
- REQ-016: EXEC lasts exactly one cycle: it registers OUT/ZERO/ERR, then goes to FIN, giving DONE 2 edges after the accepting edge.
- REQ-017: MUL runs an iterative shift-add with a 5-bit counter over DATA_W edges; the counter wraps 31->0 on exit; the unit goes to FIN, giving DONE DATA_W+1 edges after the accepting edge.
- REQ-018: FIN returns to IDLE unless START=1, which gives back-to-back acceptance with no idle cycle.
- REQ-019: Opcodes: 0x01 add, 0x02 sub, 0x03 mul, 0x04 OP1>>OP2, 0x05 OP1<<OP2, 0x06 and, 0x07 or, 0x08 nor, 0x09 unsigned OP1<OP2 (result 1 or 0).
- REQ-020: Add, sub and mul keep the low DATA_W bits (modulo 2^DATA_W); no carry or overflow is reported.
- REQ-021: Shifts are logical; an OP2 of DATA_W or more yields 0.
- REQ-022: Any other opcode, including 0x00, completes with EXEC timing: OUT=0, ZERO=1, ERR=1.
- REQ-023: ERR=0 for every supported opcode.

Reset
- REQ-024: While RST=0: state IDLE, BUSY=0, DONE=0, OUT=0, ZERO=1, ERR=0, counter 0, latched operands 0.
- REQ-025: Reset asserted mid-operation aborts it immediately; no DONE follows.
- REQ-026: START is first honoured at the first rising edge after RST deasserts.

Configuration
- REQ-027: Macro ALU_MUL_EN defined: opcode 0x03 executes per REQ-017.
- REQ-028: ALU_MUL_EN undefined: opcode 0x03 is unsupported per REQ-022, the MUL state and multiplier logic are omitted, and worst-case latency is 2 edges.

Structure
- REQ-029: Opcode constants, DATA_WIDTH and ALU_OPRN_WIDTH come from the shared prj_definition.v; state encodings are defined there as ALU_MC_* constants.
- REQ-030: The iterative multiplier is a sub-module, alu_mul_iter (ports: CLK, RST, load, OP1, OP2, product, last).

Verification
- REQ-031: OP1=15, OP2=3, OPRN=0x01, START for one cycle -> BUSY for 1 cycle, DONE 2 edges later, OUT=18, ZERO=0, ERR=0.
- REQ-032: 15*7 with ALU_MUL_EN defined -> BUSY for 32 cycles, DONE at edge 33, OUT=105; START=1 throughout BUSY is ignored and OUT remains 105.
- REQ-033: 15-15 -> OUT=0, ZERO=1; 15<16 -> OUT=1; 15<14 -> OUT=0; 15<<40 -> OUT=0; 15 nor 0 -> OUT=0xFFFFFFF0.
- REQ-034: OPRN=0x0A, and OPRN=0x03 with ALU_MUL_EN undefined -> DONE 2 edges later, OUT=0, ZERO=1, ERR=1.
- REQ-035: RST pulsed low at edge 10 of a multiply -> outputs at reset values immediately and no DONE afterwards; a new 2+2 request completes with OUT=4.
- REQ-036: START held high across FIN, with operands changed to 15 and 9 with OPRN=0x06 -> second op accepted in FIN, OUT=9 on the next DONE.

Source files
------------

// File: rtl/alu_multicycle_pkg.sv
// Types and opcode constants for the multicycle ALU; the MUL state exists only when ALU_MUL_EN is defined.
`include "prj_definition.v"

package alu_multicycle_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = `ALU_MC_IDLE,
      ST_EXEC = `ALU_MC_EXEC,
`ifdef ALU_MUL_EN
      ST_MUL  = `ALU_MC_MUL,
`endif
      ST_FIN  = `ALU_MC_FIN
   } alu_state_e;

   localparam logic [`ALU_OPRN_WIDTH-1:0] OPRN_ADD = `ALU_OPRN_ADD;
   localparam logic [`ALU_OPRN_WIDTH-1:0] OPRN_SUB = `ALU_OPRN_SUB;
   localparam logic [`ALU_OPRN_WIDTH-1:0] OPRN_MUL = `ALU_OPRN_MUL;
   localparam logic [`ALU_OPRN_WIDTH-1:0] OPRN_SHR = `ALU_OPRN_SHR;
   localparam logic [`ALU_OPRN_WIDTH-1:0] OPRN_SHL = `ALU_OPRN_SHL;
   localparam logic [`ALU_OPRN_WIDTH-1:0] OPRN_AND = `ALU_OPRN_AND;
   localparam logic [`ALU_OPRN_WIDTH-1:0] OPRN_OR  = `ALU_OPRN_OR;
   localparam logic [`ALU_OPRN_WIDTH-1:0] OPRN_NOR = `ALU_OPRN_NOR;
   localparam logic [`ALU_OPRN_WIDTH-1:0] OPRN_SLT = `ALU_OPRN_SLT;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per edge, DATA_W steps, low DATA_W bits kept.
// Present only when ALU_MUL_EN is defined.
`include "prj_definition.v"

`ifdef ALU_MUL_EN
module alu_mul_iter #(
   parameter int DATA_W = `DATA_WIDTH
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              load,
   input  logic [DATA_W-1:0] OP1,
   input  logic [DATA_W-1:0] OP2,
   output logic [DATA_W-1:0] product,
   output logic              last
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   logic [DATA_W-1:0] mcand_reg;
   logic [DATA_W-1:0] mplier_reg;
   logic [DATA_W-1:0] acc_reg;
   logic [CNT_W-1:0]  cnt_reg;
   logic              run_reg;

   // product is the accumulator after the current step, so it is final while last is high
   assign product = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
   assign last    = run_reg && (cnt_reg == CNT_W'(DATA_W - 1));

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         mcand_reg  <= '0;
         mplier_reg <= '0;
         acc_reg    <= '0;
         cnt_reg    <= '0;
         run_reg    <= 1'b0;
      end else if (load) begin
         mcand_reg  <= OP1;
         mplier_reg <= OP2;
         acc_reg    <= '0;
         cnt_reg    <= '0;
         run_reg    <= 1'b1;
      end else if (run_reg) begin
         acc_reg    <= product;
         mcand_reg  <= mcand_reg << 1;
         mplier_reg <= mplier_reg >> 1;
         cnt_reg    <= cnt_reg + 1'b1;  // wraps to 0 on the final step
         if (last) begin
            run_reg <= 1'b0;
         end
      end
   end

endmodule
`endif

// File: rtl/prj_definition.v
// Shared project definitions: datapath widths, ALU opcodes and multicycle ALU state encodings.
`ifndef PRJ_DEFINITION_V
`define PRJ_DEFINITION_V

`define DATA_WIDTH      32
`define ALU_OPRN_WIDTH  6

`define ALU_OPRN_ADD    6'h01
`define ALU_OPRN_SUB    6'h02
`define ALU_OPRN_MUL    6'h03
`define ALU_OPRN_SHR    6'h04
`define ALU_OPRN_SHL    6'h05
`define ALU_OPRN_AND    6'h06
`define ALU_OPRN_OR     6'h07
`define ALU_OPRN_NOR    6'h08
`define ALU_OPRN_SLT    6'h09

`define ALU_MC_IDLE     2'd0
`define ALU_MC_EXEC     2'd1
`define ALU_MC_MUL      2'd2
`define ALU_MC_FIN      2'd3

`endif

// File: rtl/alu_multicycle.sv
// Multicycle ALU: one-cycle EXEC for logic/arith ops, iterative MUL state when ALU_MUL_EN is defined.
`include "prj_definition.v"

module alu_multicycle
   import alu_multicycle_pkg::*;
#(
   parameter int DATA_W = `DATA_WIDTH,
   parameter int OPRN_W = `ALU_OPRN_WIDTH
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              START,
   input  logic [DATA_W-1:0] OP1,
   input  logic [DATA_W-1:0] OP2,
   input  logic [OPRN_W-1:0] OPRN,
   output logic              BUSY,
   output logic              DONE,
   output logic [DATA_W-1:0] OUT,
   output logic              ZERO,
   output logic              ERR
);

   alu_state_e        state_reg, state_next;
   logic [DATA_W-1:0] op1_reg, op2_reg;
   logic [OPRN_W-1:0] oprn_reg;
   logic [DATA_W-1:0] out_reg;
   logic              zero_reg, err_reg;

   logic              accept;
   logic              res_load;
   logic [DATA_W-1:0] alu_res, res_value;
   logic              alu_err, res_err;

`ifdef ALU_MUL_EN
   logic              mul_load;
   logic [DATA_W-1:0] mul_product;
   logic              mul_last;

   // operands go straight from the ports so the first step runs on the edge after acceptance
   assign mul_load = accept && (OPRN == OPRN_W'(OPRN_MUL));

   alu_mul_iter #(.DATA_W(DATA_W)) u_mul (
      .CLK     (CLK),
      .RST     (RST),
      .load    (mul_load),
      .OP1     (OP1),
      .OP2     (OP2),
      .product (mul_product),
      .last    (mul_last)
   );

   assign res_value = (state_reg == ST_MUL) ? mul_product : alu_res;
   assign res_err   = (state_reg == ST_MUL) ? 1'b0 : alu_err;
`else
   assign res_value = alu_res;
   assign res_err   = alu_err;
`endif

   always_comb begin
      alu_res = '0;
      alu_err = 1'b0;
      case (oprn_reg)
         OPRN_W'(OPRN_ADD): alu_res = op1_reg + op2_reg;
         OPRN_W'(OPRN_SUB): alu_res = op1_reg - op2_reg;
         OPRN_W'(OPRN_SHR): alu_res = (op2_reg >= DATA_W'(DATA_W)) ? '0 : (op1_reg >> op2_reg);
         OPRN_W'(OPRN_SHL): alu_res = (op2_reg >= DATA_W'(DATA_W)) ? '0 : (op1_reg << op2_reg);
         OPRN_W'(OPRN_AND): alu_res = op1_reg & op2_reg;
         OPRN_W'(OPRN_OR):  alu_res = op1_reg | op2_reg;
         OPRN_W'(OPRN_NOR): alu_res = ~(op1_reg | op2_reg);
         OPRN_W'(OPRN_SLT): alu_res = DATA_W'(op1_reg < op2_reg);
         default:           alu_err = 1'b1;
      endcase
   end

   always_comb begin
      state_next = state_reg;
      accept     = 1'b0;
      res_load   = 1'b0;
      case (state_reg)
         ST_IDLE, ST_FIN: begin
            if (START) begin
               accept     = 1'b1;
               state_next = ST_EXEC;
`ifdef ALU_MUL_EN
               if (OPRN == OPRN_W'(OPRN_MUL)) begin
                  state_next = ST_MUL;
               end
`endif
            end else begin
               state_next = ST_IDLE;
            end
         end
         ST_EXEC: begin
            res_load   = 1'b1;
            state_next = ST_FIN;
         end
`ifdef ALU_MUL_EN
         ST_MUL: begin
            if (mul_last) begin
               res_load   = 1'b1;
               state_next = ST_FIN;
            end
         end
`endif
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_reg <= ST_IDLE;
         op1_reg   <= '0;
         op2_reg   <= '0;
         oprn_reg  <= '0;
         out_reg   <= '0;
         zero_reg  <= 1'b1;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            op1_reg  <= OP1;
            op2_reg  <= OP2;
            oprn_reg <= OPRN;
         end
         if (res_load) begin
            out_reg  <= res_value;
            zero_reg <= (res_value == '0);
            err_reg  <= res_err;
         end
      end
   end

`ifdef ALU_MUL_EN
   assign BUSY = (state_reg == ST_EXEC) || (state_reg == ST_MUL);
`else
   assign BUSY = (state_reg == ST_EXEC);
`endif
   assign DONE = (state_reg == ST_FIN);
   assign OUT  = out_reg;
   assign ZERO = zero_reg;
   assign ERR  = err_reg;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle; expectations follow ALU_MUL_EN when defined.
module tb_alu_multicycle;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [31:0] op1, op2, out;
   logic [5:0]  oprn;
   logic        busy, done, zero, err;

   int n_checks = 0;
   int n_pass   = 0;

`ifdef ALU_MUL_EN
   localparam int  MUL_LAT  = 33;
   localparam logic [31:0] MUL_OUT = 32'd105;
   localparam logic MUL_ERR = 1'b0;
   localparam int  RST_WAIT = 9;
`else
   localparam int  MUL_LAT  = 2;
   localparam logic [31:0] MUL_OUT = 32'd0;
   localparam logic MUL_ERR = 1'b1;
   localparam int  RST_WAIT = 0;
`endif

   always #5 clk = ~clk;

   alu_multicycle dut (
      .CLK   (clk),
      .RST   (rst_n),
      .START (start),
      .OP1   (op1),
      .OP2   (op2),
      .OPRN  (oprn),
      .BUSY  (busy),
      .DONE  (done),
      .OUT   (out),
      .ZERO  (zero),
      .ERR   (err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // Issue one operation from a negedge and follow it until DONE (bounded).
   task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] op, input logic [31:0] exp_out,
                         input logic exp_err, input int exp_lat, input bit hold_start);
      int cycles = 0;
      int busy_cycles = 0;
      bit seen = 1'b0;
      @(negedge clk);
      op1 = a; op2 = b; oprn = op; start = 1'b1;
      @(posedge clk);
      #1;
      if (hold_start) begin
         op1 = 32'd1; op2 = 32'd1; oprn = 6'h01;
      end else begin
         start = 1'b0;
      end
      while (!seen && cycles < 100) begin
         @(negedge clk);
         cycles++;
         if (done) seen = 1'b1;
         else if (busy) busy_cycles++;
         if (hold_start && cycles == exp_lat - 1) start = 1'b0;
      end
      start = 1'b0;
      $display("%s: op=0x%0h a=0x%0h b=0x%0h -> out=0x%0h zero=%0b err=%0b lat=%0d busy=%0d",
               name, op, a, b, out, zero, err, cycles, busy_cycles);
      check({name, ".done_seen"}, 32'(seen), 32'd1);
      check({name, ".latency"},   32'(cycles), 32'(exp_lat));
      check({name, ".busy_cyc"},  32'(busy_cycles), 32'(exp_lat - 1));
      check({name, ".out"},       out, exp_out);
      check({name, ".zero"},      32'(zero), 32'(exp_out == 32'd0));
      check({name, ".err"},       32'(err), 32'(exp_err));
      @(negedge clk);
      check({name, ".done_pulse"}, 32'(done), 32'd0);
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, ".busy"}, 32'(busy), 32'd0);
      check({name, ".done"}, 32'(done), 32'd0);
      check({name, ".out"},  out, 32'd0);
      check({name, ".zero"}, 32'(zero), 32'd1);
      check({name, ".err"},  32'(err), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int done_count;
      rst_n = 1'b0; start = 1'b0; op1 = '0; op2 = '0; oprn = '0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      $display("reset: busy=%0b done=%0b out=0x%0h zero=%0b err=%0b", busy, done, out, zero, err);
      rst_n = 1'b1;

      run_op("add",     32'd15,   32'd3,  6'h01, 32'd18,         1'b0, 2, 1'b0);
      run_op("mul",     32'd15,   32'd7,  6'h03, MUL_OUT,        MUL_ERR, MUL_LAT, 1'b1);
      run_op("sub",     32'd15,   32'd15, 6'h02, 32'd0,          1'b0, 2, 1'b0);
      run_op("slt_t",   32'd15,   32'd16, 6'h09, 32'd1,          1'b0, 2, 1'b0);
      run_op("slt_f",   32'd15,   32'd14, 6'h09, 32'd0,          1'b0, 2, 1'b0);
      run_op("shl_big", 32'd15,   32'd40, 6'h05, 32'd0,          1'b0, 2, 1'b0);
      run_op("shl",     32'd15,   32'd4,  6'h05, 32'hF0,         1'b0, 2, 1'b0);
      run_op("shr",     32'hF0,   32'd4,  6'h04, 32'hF,          1'b0, 2, 1'b0);
      run_op("shr_big", 32'hF0,   32'd32, 6'h04, 32'd0,          1'b0, 2, 1'b0);
      run_op("or",      32'hF0,   32'h0F, 6'h07, 32'hFF,         1'b0, 2, 1'b0);
      run_op("add_wrap",32'hFFFFFFFF, 32'd2, 6'h01, 32'd1,       1'b0, 2, 1'b0);
      run_op("bad_0a",  32'd15,   32'd3,  6'h0A, 32'd0,          1'b1, 2, 1'b0);
      run_op("bad_00",  32'd15,   32'd3,  6'h00, 32'd0,          1'b1, 2, 1'b0);
      run_op("nor",     32'd15,   32'd0,  6'h08, 32'hFFFFFFF0,   1'b0, 2, 1'b0);

      // Abort a running operation with reset; nothing may complete afterwards.
      @(negedge clk);
      op1 = 32'd15; op2 = 32'd7; oprn = 6'h03; start = 1'b1;
      if (RST_WAIT == 0) oprn = 6'h01;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (RST_WAIT) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_abort");
      $display("rst_abort: busy=%0b done=%0b out=0x%0h zero=%0b err=%0b", busy, done, out, zero, err);
      @(negedge clk);
      rst_n = 1'b1;
      done_count = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) done_count++;
      end
      check("rst_abort.no_done", 32'(done_count), 32'd0);
      run_op("post_rst", 32'd2, 32'd2, 6'h01, 32'd4, 1'b0, 2, 1'b0);

      // Back-to-back: START held through FIN accepts the next op without an idle cycle.
      @(negedge clk);
      op1 = 32'd1; op2 = 32'd1; oprn = 6'h01; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      op1 = 32'd15; op2 = 32'd9; oprn = 6'h06;
      check("b2b.busy1", 32'(busy), 32'd1);
      @(negedge clk);
      check("b2b.done1", 32'(done), 32'd1);
      check("b2b.out1", out, 32'd2);
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      check("b2b.busy2", 32'(busy), 32'd1);
      @(negedge clk);
      check("b2b.done2", 32'(done), 32'd1);
      check("b2b.out2", out, 32'd9);
      $display("b2b: second op and 15&9 -> out=0x%0h done=%0b", out, done);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
